// File: rtl/alu_seq.sv
// Sequenced ALU controller: queues {op, a, b, d, last} commands, reads two RAM
// operands, starts the ALU, waits for its result with a timeout, and writes the
// result back to RAM. SYNC commands only mark the end of a sequence.
module alu_seq #(
    parameter int unsigned WID   = 256,
    parameter int unsigned AWID  = 5,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TMO   = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    input  logic [1:0]      cmd_op,
    input  logic [AWID-1:0] cmd_a,
    input  logic [AWID-1:0] cmd_b,
    input  logic [AWID-1:0] cmd_d,
    input  logic            cmd_last,
    output logic            cmd_rdy,
    input  logic            clr_err,
    output logic [AWID-1:0] ramra,
    output logic [WID-1:0]  ramwd,
    output logic [AWID-1:0] ramwa,
    output logic            ramwe,
    output logic            aen,
    output logic [1:0]      aop,
    input  logic [WID-1:0]  adi,
    input  logic            adivld,
    output logic            busy,
    output logic            seqdone,
    output logic            seqerr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [1:0] OpSync = 2'd3;

    typedef struct packed {
        logic [1:0]      op;
        logic [AWID-1:0] a;
        logic [AWID-1:0] b;
        logic [AWID-1:0] d;
        logic            last;
    } cmd_t;

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StIssue, StWait, StWb} state_e;

    cmd_t            mem_q [DEPTH];
    cmd_t            cur_q, cur_d, cmd_in;
    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            seqerr_q, seqerr_d;
    logic [AWID-1:0] ramra_q, ramra_d, ramwa_q, ramwa_d;
    logic [WID-1:0]  ramwd_q, ramwd_d;
    logic            ramwe_q, ramwe_d, aen_q, aen_d, seqdone_q, seqdone_d;
    logic [1:0]      aop_q, aop_d;
    logic            empty, full, push, pop, timeout;

    assign cmd_in  = '{op: cmd_op, a: cmd_a, b: cmd_b, d: cmd_d, last: cmd_last};
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign cmd_rdy = !full && !seqerr_q;
    assign push    = cmd_vld && cmd_rdy;
    assign pop     = (state_q == StIdle) && !empty;
    // TMO-th consecutive WAIT cycle without a result
    assign timeout = (state_q == StWait) && !adivld && (tmo_q == TW'(TMO - 1));

    // Next-state logic for the queue, sequencer and registered outputs
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tmo_d     = tmo_q;
        ramra_d   = ramra_q;
        ramwd_d   = ramwd_q;
        ramwa_d   = ramwa_q;
        aop_d     = aop_q;
        ramwe_d   = 1'b0;
        aen_d     = 1'b0;
        seqdone_d = 1'b0;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        seqerr_d  = clr_err ? 1'b0 : seqerr_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    cur_d = mem_q[rd_ptr_q];
                    if (mem_q[rd_ptr_q].op == OpSync) begin
                        state_d   = StWb;
                        seqdone_d = mem_q[rd_ptr_q].last;
                    end else begin
                        state_d = StRdA;
                        ramra_d = mem_q[rd_ptr_q].a;
                    end
                end
            end
            StRdA: begin
                state_d = StRdB;
                ramra_d = cur_q.b;
            end
            StRdB: begin
                state_d = StIssue;
                aen_d   = 1'b1;
                aop_d   = cur_q.op;
            end
            StIssue: begin
                state_d = StWait;
                tmo_d   = '0;
            end
            StWait: begin
                if (adivld) begin
                    state_d   = StWb;
                    ramwd_d   = adi;
                    ramwe_d   = 1'b1;
                    ramwa_d   = cur_q.d;
                    seqdone_d = cur_q.last;
                end else if (timeout) begin
                    // Abandon the op and drop everything queued behind it
                    state_d  = StIdle;
                    seqerr_d = 1'b1;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWb: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            seqerr_q  <= 1'b0;
            ramra_q   <= '0;
            ramwd_q   <= '0;
            ramwa_q   <= '0;
            ramwe_q   <= 1'b0;
            aen_q     <= 1'b0;
            aop_q     <= '0;
            seqdone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            seqerr_q  <= seqerr_d;
            ramra_q   <= ramra_d;
            ramwd_q   <= ramwd_d;
            ramwa_q   <= ramwa_d;
            ramwe_q   <= ramwe_d;
            aen_q     <= aen_d;
            aop_q     <= aop_d;
            seqdone_q <= seqdone_d;
        end
    end

    assign ramra   = ramra_q;
    assign ramwd   = ramwd_q;
    assign ramwa   = ramwa_q;
    assign ramwe   = ramwe_q;
    assign aen     = aen_q;
    assign aop     = aop_q;
    assign seqdone = seqdone_q;
    assign seqerr  = seqerr_q;
    assign busy    = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table-driven single-command vectors, hand-written corner
// sequences, and a randomized run checked against an in-order command model.
module tb_alu_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b0, cmd_vld = 1'b0, cmd_last = 1'b0, clr_err = 1'b0, adivld = 1'b0;
    logic [1:0]   cmd_op = '0;
    logic [4:0]   cmd_a = '0, cmd_b = '0, cmd_d = '0;
    logic [255:0] adi = '0;

    logic         m_cmd_rdy, m_ramwe, m_aen, m_busy, m_seqdone, m_seqerr;
    logic [4:0]   m_ramra, m_ramwa;
    logic [255:0] m_ramwd;
    logic [1:0]   m_aop;
    logic         t_cmd_rdy, t_ramwe, t_aen, t_busy, t_seqdone, t_seqerr;
    logic [4:0]   t_ramra, t_ramwa;
    logic [255:0] t_ramwd;
    logic [1:0]   t_aop;

    alu_seq #(.WID(256), .AWID(5), .DEPTH(8), .TMO(20)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_a(cmd_a),
        .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_last(cmd_last), .cmd_rdy(m_cmd_rdy),
        .clr_err(clr_err), .ramra(m_ramra), .ramwd(m_ramwd), .ramwa(m_ramwa),
        .ramwe(m_ramwe), .aen(m_aen), .aop(m_aop), .adi(adi), .adivld(adivld),
        .busy(m_busy), .seqdone(m_seqdone), .seqerr(m_seqerr)
    );

    alu_seq #(.WID(256), .AWID(5), .DEPTH(8), .TMO(4)) dut_t (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_a(cmd_a),
        .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_last(cmd_last), .cmd_rdy(t_cmd_rdy),
        .clr_err(clr_err), .ramra(t_ramra), .ramwd(t_ramwd), .ramwa(t_ramwa),
        .ramwe(t_ramwe), .aen(t_aen), .aop(t_aop), .adi(adi), .adivld(adivld),
        .busy(t_busy), .seqdone(t_seqdone), .seqerr(t_seqerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op; logic [4:0] a; logic [4:0] b; logic [4:0] d; logic last;
        logic [255:0] adi;
        logic exp_we; logic [4:0] exp_wa; logic [255:0] exp_wd; logic exp_done;
    } vec_t;
    typedef struct { logic [1:0] op; logic [4:0] a; logic [4:0] b; logic [4:0] d; logic last; } bcmd_t;
    typedef struct { logic [4:0] wa; logic [255:0] wd; logic done; } wr_t;

    int n_cmp = 0, n_bad = 0;
    vec_t vt[7];
    bcmd_t mq[$];
    wr_t obs_q[$];
    logic [255:0] resp_q[$];
    logic [1:0] aop_obs[$];
    logic auto_resp = 1'b0, rand_dly = 1'b0;
    int t_we_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; cmd_vld = 1'b0; adivld = 1'b0; clr_err = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Drive a push in the current cycle; returns one cycle later with cmd_vld low
    task automatic push(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic last);
        cmd_vld = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d; cmd_last = last;
        step();
        cmd_vld = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        push(v.op, v.a, v.b, v.d, v.last);                 // now at T+1
        if (v.op != 2'd3) begin
            step(); chk("ramra_a", m_ramra, v.a);          // T+2
            step(); chk("ramra_b", m_ramra, v.b); chk("aen_early", m_aen, 0);
            step(); chk("aen", m_aen, 1); chk("aop", m_aop, v.op);
            step(); chk("aen_one", m_aen, 0);              // T+5
            step(); adivld = 1'b1; adi = v.adi;            // T+6
            step(); adivld = 1'b0;                         // T+7
        end else begin
            step();                                        // T+2
        end
        chk("wb_ramwe", m_ramwe, v.exp_we);
        chk("wb_ramwa", m_ramwa, v.exp_wa);
        chk("wb_ramwd", m_ramwd, v.exp_wd);
        chk("wb_seqdone", m_seqdone, v.exp_done);
        step();
        chk("post_ramwe", m_ramwe, 0); chk("post_seqdone", m_seqdone, 0);
        chk("post_busy", m_busy, 0);
    endtask

    // Records main-DUT RAM writes and counts writes from the short-timeout DUT
    always @(negedge clk) begin
        if (m_ramwe) obs_q.push_back('{m_ramwa, m_ramwd, m_seqdone});
        if (t_ramwe) t_we_cnt++;
    end

    // Automatic ALU responder for the main DUT
    always begin
        int k;
        @(negedge clk);
        if (auto_resp && m_aen) begin
            logic [255:0] r;
            aop_obs.push_back(m_aop);
            k = rand_dly ? $urandom_range(1, 4) : 1;
            repeat (k) @(negedge clk);
            r = rnd256();
            adivld = 1'b1; adi = r;
            resp_q.push_back(r);
            @(negedge clk);
            adivld = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, g;
        bcmd_t c;
        vt[0] = '{2'd1, 5'd2,  5'd3,  5'd4,  1'b1, 256'd3251231251234,
                  1'b1, 5'd4,  256'd3251231251234, 1'b1};
        vt[1] = '{2'd0, 5'd5,  5'd6,  5'd7,  1'b0, 256'd3, 1'b1, 5'd7,  256'd3, 1'b0};
        vt[2] = '{2'd2, 5'd8,  5'd9,  5'd10, 1'b0, 256'd4, 1'b1, 5'd10, 256'd4, 1'b0};
        vt[3] = '{2'd3, 5'd0,  5'd0,  5'd31, 1'b1, 256'd0, 1'b0, 5'd10, 256'd4, 1'b1};
        vt[4] = '{2'd3, 5'd0,  5'd0,  5'd1,  1'b0, 256'd0, 1'b0, 5'd10, 256'd4, 1'b0};
        vt[5] = '{2'd0, 5'd31, 5'd0,  5'd31, 1'b1, {256{1'b1}}, 1'b1, 5'd31, {256{1'b1}}, 1'b1};
        vt[6] = '{2'd1, 5'd0,  5'd31, 5'd0,  1'b0, {1'b1, 255'd0}, 1'b1, 5'd0, {1'b1, 255'd0}, 1'b0};

        // Reset state
        step();
        do_reset();
        chk("rst_ramra", m_ramra, 0); chk("rst_ramwd", m_ramwd, 0);
        chk("rst_ramwa", m_ramwa, 0); chk("rst_ramwe", m_ramwe, 0);
        chk("rst_aen", m_aen, 0); chk("rst_aop", m_aop, 0);
        chk("rst_seqdone", m_seqdone, 0); chk("rst_seqerr", m_seqerr, 0);
        chk("rst_busy", m_busy, 0); chk("rst_cmd_rdy", m_cmd_rdy, 1);

        // Table vectors, including the FA, INV, SYNC(last) sequence
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // adivld outside WAIT is ignored
        do_reset();
        run_vec(vt[1]);
        adivld = 1'b1; adi = 256'd7;
        step(); adivld = 1'b0;
        chk("idle_adivld_wd", m_ramwd, 3); chk("idle_adivld_we", m_ramwe, 0);
        step(); chk("idle_adivld_busy", m_busy, 0);
        push(2'd2, 5'd1, 5'd2, 5'd12, 1'b0);
        step(); step();                                    // T+3, RDB
        adivld = 1'b1; adi = 256'd7;
        step(); adivld = 1'b0;
        chk("rdb_adivld_wd", m_ramwd, 3); chk("rdb_aen", m_aen, 1);
        step(); step();
        adivld = 1'b1; adi = 256'd9;
        step(); adivld = 1'b0;
        chk("after_rdb_we", m_ramwe, 1); chk("after_rdb_wd", m_ramwd, 9);
        chk("after_rdb_wa", m_ramwa, 12);
        step();

        // Reset while waiting on the ALU, then a stale result
        push(2'd0, 5'd1, 5'd2, 5'd5, 1'b1);
        step(); step(); step(); step();                    // T+5, WAIT
        chk("mid_busy", m_busy, 1);
        rst = 1'b1;
        step(); rst = 1'b0; adivld = 1'b1; adi = 256'd11;  // T+6
        step(); adivld = 1'b0;
        chk("mrst_ramwe", m_ramwe, 0); chk("mrst_seqdone", m_seqdone, 0);
        chk("mrst_ramra", m_ramra, 0); chk("mrst_ramwd", m_ramwd, 0);
        chk("mrst_ramwa", m_ramwa, 0); chk("mrst_aop", m_aop, 0);
        chk("mrst_aen", m_aen, 0); chk("mrst_busy", m_busy, 0);
        chk("mrst_seqerr", m_seqerr, 0); chk("mrst_cmd_rdy", m_cmd_rdy, 1);
        step(); chk("mrst_ramwe2", m_ramwe, 0);

        // Timeout with TMO=4, clr_err overlapping the timeout cycle
        do_reset();
        t_we_cnt = 0;
        push(2'd1, 5'd1, 5'd2, 5'd3, 1'b1);
        push(2'd0, 5'd1, 5'd2, 5'd4, 1'b1);
        push(2'd0, 5'd1, 5'd2, 5'd5, 1'b1);                // now T+3
        step(); chk("tmo_aen", t_aen, 1);                  // T+4
        step(); step(); step(); chk("tmo_no_err_yet", t_seqerr, 0);  // T+7
        clr_err = 1'b1;
        step();                                            // T+8
        chk("tmo_err_pre", t_seqerr, 0);
        step();                                            // T+9
        chk("tmo_seqerr", t_seqerr, 1); chk("tmo_cmd_rdy", t_cmd_rdy, 0);
        chk("tmo_busy", t_busy, 0); chk("tmo_seqdone", t_seqdone, 0);
        step(); clr_err = 1'b0;                            // T+10
        chk("clr_seqerr", t_seqerr, 0); chk("clr_cmd_rdy", t_cmd_rdy, 1);
        step(); step(); chk("tmo_flushed", t_busy, 0);
        chk("tmo_no_write", t_we_cnt, 0);

        // Result on the TMO-th WAIT cycle is accepted
        do_reset();
        push(2'd1, 5'd1, 5'd2, 5'd9, 1'b1);                // T+1
        repeat (7) step();                                 // T+8
        adivld = 1'b1; adi = 256'd77;
        step(); adivld = 1'b0;
        chk("edge_we", t_ramwe, 1); chk("edge_wd", t_ramwd, 77);
        chk("edge_done", t_seqdone, 1); chk("edge_err", t_seqerr, 0);

        // Fill the queue; pushes while full are dropped
        do_reset();
        obs_q.delete(); resp_q.delete(); aop_obs.delete();
        for (int i = 0; i < 9; i++) begin
            cmd_vld = 1'b1; cmd_op = 2'd1; cmd_a = 5'd0; cmd_b = 5'd0;
            cmd_d = 5'(i); cmd_last = 1'b0;
            chk("fill_rdy", m_cmd_rdy, 1);
            step();
        end
        chk("full_rdy", m_cmd_rdy, 0);                     // T+9
        cmd_d = 5'd30; step();
        chk("full_rdy2", m_cmd_rdy, 0);
        cmd_d = 5'd31; step();                             // T+11
        cmd_vld = 1'b0; adivld = 1'b1; adi = 256'd100;
        step(); adivld = 1'b0; auto_resp = 1'b1; rand_dly = 1'b0;  // T+12
        step(); chk("full_after_wb", m_cmd_rdy, 0);        // T+13
        step(); chk("rdy_after_pop", m_cmd_rdy, 1);        // T+14
        g = 0;
        while (m_busy && g < 1000) begin step(); g++; end
        chk("fill_drained", m_busy, 0);
        chk("fill_nwrites", obs_q.size(), 9);
        for (int i = 0; i < obs_q.size() && i < 9; i++) chk("fill_wa", obs_q[i].wa, i);
        auto_resp = 1'b0;

        // Randomized traffic against the in-order model
        do_reset();
        obs_q.delete(); resp_q.delete(); aop_obs.delete(); mq.delete();
        auto_resp = 1'b1; rand_dly = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            g = 0;
            while (!m_cmd_rdy && g < 300) begin step(); g++; end
            chk("rnd_rdy", m_cmd_rdy, 1);
            c.op = 2'($urandom_range(0, 2)); c.a = 5'($urandom); c.b = 5'($urandom);
            c.d = 5'($urandom); c.last = 1'($urandom);
            cmd_vld = 1'b1; cmd_op = c.op; cmd_a = c.a; cmd_b = c.b;
            cmd_d = c.d; cmd_last = c.last;
            mq.push_back(c);
            step();
            cmd_vld = 1'b0;
        end
        g = 0;
        while (obs_q.size() < 40 && g < 3000) begin step(); g++; end
        step(); step();
        chk("rnd_count", obs_q.size(), 40);
        for (int i = 0; i < 40 && i < obs_q.size() && i < resp_q.size() && i < aop_obs.size();
             i++) begin
            chk("rnd_aop", aop_obs[i], mq[i].op);
            chk("rnd_wa", obs_q[i].wa, mq[i].d);
            chk("rnd_wd", obs_q[i].wd, resp_q[i]);
            chk("rnd_done", obs_q[i].done, mq[i].last);
        end
        auto_resp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WID, 256, ALU/RAM data width in bits.
REQ-002 Parameter AWID, 5, RAM address width.
REQ-003 Parameter DEPTH, 8, command queue depth; power of two, at least 2.
REQ-004 Parameter TMO, 255, ALU response timeout in cycles; at least 1.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_vld  in  1  command push strobe.
- cmd_op  in  2  operation: 0 FA, 1 MUL, 2 INV, 3 SYNC.
- cmd_a  in  AWID  source A RAM address.
- cmd_b  in  AWID  source B RAM address.
- cmd_d  in  AWID  destination RAM address.
- cmd_last  in  1  command ends a sequence.
- cmd_rdy  out  1  queue can accept a push.
- clr_err  in  1  clears seqerr.
- ramra  out  AWID  RAM read address.
- ramwd  out  WID  RAM write data.
- ramwa  out  AWID  RAM write address.
- ramwe  out  1  RAM write enable.
- aen  out  1  ALU start pulse.
- aop  out  2  ALU operation.
- adi  in  WID  ALU result.
- adivld  in  1  ALU result valid.
- busy  out  1  FSM not IDLE or queue not empty.
- seqdone  out  1  sequence complete pulse.
- seqerr  out  1  sticky timeout error.

Function
REQ-007 The command queue SHALL be a DEPTH-entry FIFO holding {op, a, b, d, last}.
REQ-008 Push: a push SHALL occur when cmd_vld=1 and cmd_rdy=1; cmd_vld while cmd_rdy=0 SHALL be dropped.
REQ-009 cmd_rdy SHALL be 1 only when the queue is not full and seqerr=0.
REQ-010 A push and a pop in the same cycle SHALL both succeed, leaving occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-011 FSM states: IDLE, RDA, RDB, ISSUE, WAIT, WB.
REQ-012 IDLE: if the queue is non-empty, the block SHALL pop and latch the head entry; SYNC goes to WB, any other op goes to RDA.
REQ-013 RDA: ramra=a for one cycle, then RDB.
REQ-014 RDB: ramra=b for one cycle, then ISSUE.
REQ-015 ISSUE: aen=1 and aop=op for exactly one cycle, then WAIT.
REQ-016 WAIT: on adivld=1 the block SHALL capture adi into ramwd and go to WB.
REQ-017 WB: ramwe=1 and ramwa=d for one cycle (ramwe=0 for SYNC); seqdone=1 in the same cycle if last=1; then IDLE.
REQ-018 Latency, empty idle block: push at cycle T -> pop at T+1 -> aen at T+4.
REQ-019 Latency: adivld at cycle W -> ramwe at W+1.
REQ-020 Throughput: minimum 6 cycles per ALU op (ALU answering in 1 cycle), 2 cycles per SYNC.
REQ-021 adivld outside WAIT SHALL be ignored.
REQ-022 ramra, ramwa and aop SHALL hold their last value when not in use.
REQ-023 Timeout: a counter cleared on entry to WAIT SHALL count WAIT cycles without adivld.
REQ-024 On the TMO-th such cycle, the next cycle SHALL set seqerr=1, flush the queue, return to IDLE, and issue no ramwe and no seqdone.
REQ-025 adivld on the TMO-th WAIT cycle SHALL be accepted normally, with no error.
REQ-026 clr_err=1 SHALL clear seqerr the next cycle; a timeout in the same cycle SHALL win, leaving seqerr=1.
REQ-027 busy SHALL equal (state!=IDLE) or (queue non-empty).

Reset
REQ-028 rst=1 SHALL force IDLE, empty the queue, zero the timeout counter, and drive ramra=0, ramwd=0, ramwa=0, ramwe=0, aen=0, aop=0, seqdone=0, seqerr=0, busy=0; cmd_rdy=1 the cycle after rst deasserts.
REQ-029 Reset mid-operation SHALL abandon the current op with no write and no seqdone; adivld arriving after reset SHALL be ignored.

Verification
REQ-030 Single MUL: push {op=1,a=2,b=3,d=4,last=1} at T, adivld with adi=3251231251234 at T+6 -> aen at T+4 with aop=1; ramra=2 at T+2, ramra=3 at T+3; ramwe at T+7 with ramwa=4, ramwd=3251231251234; seqdone at T+7.
REQ-031 Fill/full: push 9 commands back-to-back with no adivld (DEPTH=8) -> cmd_rdy=0 after occupancy 8, extra pushes dropped, occupancy stays 8 after the first pop.
REQ-032 Sequence of FA, INV, SYNC(last=1) with adi=3, 4 -> two writes in order, then seqdone in the SYNC WB cycle, which has ramwe=0.
REQ-033 Timeout with TMO=4 and no adivld -> seqerr=1 five cycles after aen, queue empty, cmd_rdy=0, no ramwe; clr_err -> cmd_rdy=1 the following cycle.
REQ-034 rst asserted in WAIT, then adivld=1 -> no ramwe, no seqdone, all outputs at reset values.
REQ-035 adivld=1 with adi=7 while in IDLE or RDB -> ignored; ramwd stays unchanged.
